// File: rtl/iqdemap_multi.sv
// iqdemap_multi: multi-mode hard-decision IQ demapper with LSB-first word packing.
//
// Stage 1 slices one complex symbol per valid_i as BPSK, QPSK or 16-QAM and
// presents the decided bits on the raw tap. Stage 2 packs those bits into
// DW-bit words, emitting on a full word or on a flush of a partial word.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   valid_i           symbol strobe, no backpressure
//   ar, ai            signed I/Q samples (IW bits)
//   mode_i            0=BPSK 1=QPSK 2=16QAM 3=QPSK, latched per word
//   qam_thr           16QAM inner/outer threshold (IW-1 bits, unsigned)
//   flush_i           close the current partial word
//   valid_raw/raw/raw_k  per-symbol decision tap (raw_k bits valid in raw)
//   valid_o/data_o/nbits_o  packed word strobe, word, valid bit count
module iqdemap_multi #(
    parameter int  IW = 11,
    parameter int  DW = 32,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 valid_i,
    input  logic signed [IW-1:0] ar,
    input  logic signed [IW-1:0] ai,
    input  logic [1:0]           mode_i,
    input  logic [IW-2:0]        qam_thr,
    input  logic                 flush_i,
    output logic                 valid_raw,
    output logic [3:0]           raw,
    output logic [2:0]           raw_k,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o,
    output logic [CW-1:0]        nbits_o
);

    typedef enum logic [1:0] {
        M_BPSK  = 2'd0,
        M_QPSK  = 2'd1,
        M_QAM16 = 2'd2,
        M_RSVD  = 2'd3
    } mode_e;

    // ---------------- Stage 1: decision ----------------
    mode_e          word_mode_q, mode_sel;
    logic [CW-1:0]  sym_cnt_q, sym_cnt_d, spw;
    logic [2:0]     k_sel;
    logic [3:0]     raw_d;
    logic           flush_q;

    // Magnitudes are one bit wider than the sample so -2^(IW-1) does not wrap.
    logic [IW:0] ar_x, ai_x, ar_abs, ai_abs, thr_x;

    always_comb begin
        ar_x   = {ar[IW-1], ar};
        ai_x   = {ai[IW-1], ai};
        ar_abs = ar[IW-1] ? (~ar_x + {{IW{1'b0}}, 1'b1}) : ar_x;
        ai_abs = ai[IW-1] ? (~ai_x + {{IW{1'b0}}, 1'b1}) : ai_x;
        thr_x  = {2'b00, qam_thr};
    end

    // A new word takes mode_i; mid-word symbols reuse the latched mode.
    always_comb begin
        mode_sel = (sym_cnt_q == '0) ? mode_e'(mode_i) : word_mode_q;
        if (mode_sel == M_RSVD) mode_sel = M_QPSK;
    end

    always_comb begin
        k_sel = 3'd2;
        spw   = CW'(DW / 2);
        raw_d = {2'b00, ai[IW-1], ar[IW-1]};
        case (mode_sel)
            M_BPSK: begin
                k_sel = 3'd1;
                spw   = CW'(DW);
                raw_d = {3'b000, ar[IW-1]};
            end
            M_QAM16: begin
                k_sel = 3'd4;
                spw   = CW'(DW / 4);
                raw_d = {ai_abs < thr_x, ai[IW-1], ar_abs < thr_x, ar[IW-1]};
            end
            default: ;
        endcase
    end

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (valid_i)
            sym_cnt_d = (sym_cnt_q + CW'(1) == spw) ? '0 : sym_cnt_q + CW'(1);
        if (flush_i)
            sym_cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_raw   <= 1'b0;
            raw         <= 4'd0;
            raw_k       <= 3'd2;
            flush_q     <= 1'b0;
            sym_cnt_q   <= '0;
            word_mode_q <= M_QPSK;
        end else begin
            valid_raw <= valid_i;
            flush_q   <= flush_i;
            sym_cnt_q <= sym_cnt_d;
            if (valid_i) begin
                raw   <= raw_d;
                raw_k <= k_sel;
                if (sym_cnt_q == '0) word_mode_q <= mode_sel;
            end
        end
    end

    // ---------------- Stage 2: collector ----------------
    logic [DW-1:0] acc_q, acc_add;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          emit;

    always_comb begin
        acc_add = acc_q;
        cnt_n   = cnt_q;
        if (valid_raw) begin
            acc_add = acc_q | ({{(DW-4){1'b0}}, raw} << cnt_q);
            cnt_n   = cnt_q + CW'(raw_k);
        end
        // A full word wins over a coincident flush, so only one word leaves.
        emit = (cnt_n == CW'(DW)) || (flush_q && (cnt_n != '0));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
            nbits_o <= '0;
        end else if (emit) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_o <= 1'b1;
            data_o  <= acc_add;
            nbits_o <= cnt_n;
        end else begin
            acc_q   <= acc_add;
            cnt_q   <= cnt_n;
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iqdemap_multi.sv
// Bench for iqdemap_multi: behavioural word/symbol model checked every cycle,
// plus directed scenarios with hand-computed words and raw decisions.
module tb_iqdemap_multi;
    localparam int IW = 11;
    localparam int DW = 32;
    localparam int CW = $clog2(DW + 1);

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 valid_i = 1'b0, flush_i = 1'b0;
    logic signed [IW-1:0] ar = '0, ai = '0;
    logic [1:0]           mode_i = 2'd1;
    logic [IW-2:0]        qam_thr = 200;
    logic                 valid_raw, valid_o;
    logic [3:0]           raw;
    logic [2:0]           raw_k;
    logic [DW-1:0]        data_o;
    logic [CW-1:0]        nbits_o;

    iqdemap_multi #(.IW(IW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .valid_i(valid_i), .ar(ar), .ai(ai),
        .mode_i(mode_i), .qam_thr(qam_thr), .flush_i(flush_i),
        .valid_raw(valid_raw), .raw(raw), .raw_k(raw_k),
        .valid_o(valid_o), .data_o(data_o), .nbits_o(nbits_o)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] decide(input int md, input int a, input int b, input int thr);
        int aa, bb;
        aa = (a < 0) ? -a : a;
        bb = (b < 0) ? -b : b;
        case (md)
            0:       return {3'b000, a < 0};
            1:       return {2'b00, b < 0, a < 0};
            default: return {bb < thr, b < 0, aa < thr, a < 0};
        endcase
    endfunction

    int     m_cnt, m_mode, e_k, w_n, e_nb;
    longint m_data, w_d, e_data;
    bit     e_vraw, w_v, e_vo;
    logic [3:0] e_raw;

    always @(posedge CLK or negedge RST) begin
        int md, k, cnt;
        longint d;
        logic [3:0] r;
        if (!RST) begin
            m_cnt <= 0; m_mode <= 1; m_data <= 0;
            e_vraw <= 0; e_raw <= 0; e_k <= 2;
            w_v <= 0; w_d <= 0; w_n <= 0;
            e_vo <= 0; e_data <= 0; e_nb <= 0;
        end else begin
            cnt = m_cnt;
            d   = m_data;
            e_vo <= w_v;
            if (w_v) begin e_data <= w_d; e_nb <= w_n; end
            e_vraw <= valid_i;
            if (valid_i) begin
                md = (cnt == 0) ? ((mode_i == 2'd3) ? 1 : int'(mode_i)) : m_mode;
                k  = (md == 0) ? 1 : (md == 1) ? 2 : 4;
                r  = decide(md, int'(ar), int'(ai), int'(qam_thr));
                e_raw <= r;
                e_k   <= k;
                m_mode <= md;
                d   = d + (longint'(r) << cnt);
                cnt = cnt + k;
            end
            if (cnt == DW || (flush_i && cnt > 0)) begin
                w_v <= 1; w_d <= d; w_n <= cnt;
                cnt = 0; d = 0;
            end else begin
                w_v <= 0;
            end
            m_cnt  <= cnt;
            m_data <= d;
        end
    end

    // ---------------- compare process ----------------
    typedef struct { longint d; int n; int c; } word_t;
    word_t wq[$];
    int    rq[$];

    always @(negedge CLK) begin
        if (RST) begin
            chk("valid_raw", valid_raw, e_vraw);
            chk("raw", raw, e_raw);
            chk("raw_k", raw_k, e_k);
            chk("valid_o", valid_o, e_vo);
            chk("data_o", data_o, e_data);
            chk("nbits_o", nbits_o, e_nb);
            if (valid_o) wq.push_back('{longint'(data_o), int'(nbits_o), cyc});
            if (valid_raw) rq.push_back(int'(raw));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int a, input int b, input int m, input bit v, input bit f);
        ar = IW'(a); ai = IW'(b); mode_i = m[1:0]; valid_i = v; flush_i = f;
        @(posedge CLK); #1;
        valid_i = 0; flush_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, int'(mode_i), 0, 0);
    endtask

    task automatic expect_word(input string nm, input longint d, input int n, input int lc);
        word_t w;
        chk({nm, " count"}, wq.size() > 0, 1);
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk({nm, " data"}, w.d, d);
            chk({nm, " nbits"}, w.n, n);
            if (lc >= 0) chk({nm, " latency"}, w.c - lc, 2);
        end
    endtask

    int lc;
    int qam_ar[4] = '{-1024, -200, 199, 300};

    initial begin
        #2 RST = 0;
        #6;
        chk("rst valid_raw", valid_raw, 0);
        chk("rst raw", raw, 0);
        chk("rst raw_k", raw_k, 2);
        chk("rst valid_o", valid_o, 0);
        chk("rst data_o", data_o, 0);
        chk("rst nbits_o", nbits_o, 0);
        @(posedge CLK); #1 RST = 1;
        idle(2);

        // QPSK alternating: raw 2,1 per pair -> nibble 0110
        rq.delete();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) lc = cyc;
            step((i % 2) ? -100 : 100, (i % 2) ? 100 : -100, 1, 1, 0);
        end
        idle(3);
        expect_word("qpsk", 64'h66666666, 32, lc);
        chk("qpsk raw0", rq.size() > 1 ? rq[0] : -1, 2);
        chk("qpsk raw1", rq.size() > 1 ? rq[1] : -1, 1);

        // BPSK, mode_i switched to 16QAM mid-word is ignored
        for (int i = 0; i < 32; i++)
            step((i % 2) ? 1 : -1, 0, (i >= 10) ? 2 : 0, 1, 0);
        idle(3);
        expect_word("bpsk", 64'h55555555, 32, -1);

        // 16QAM thr=200, ai=0 -> raw 9,9,A,8
        rq.delete();
        for (int i = 0; i < 8; i++)
            step(qam_ar[i % 4], 0, 2, 1, 0);
        idle(3);
        expect_word("qam", 64'h8A998A99, 32, -1);
        chk("qam raw0", rq.size() > 3 ? rq[0] : -1, 9);
        chk("qam raw1", rq.size() > 3 ? rq[1] : -1, 9);
        chk("qam raw2", rq.size() > 3 ? rq[2] : -1, 10);
        chk("qam raw3", rq.size() > 3 ? rq[3] : -1, 8);

        // Partial-word flush, then an empty flush
        for (int i = 0; i < 5; i++) begin
            if (i == 4) lc = cyc;
            step(100, -100, 1, 1, i == 4);
        end
        idle(3);
        expect_word("flush", 64'h2AA, 10, lc);
        step(0, 0, 1, 0, 1);
        idle(3);
        chk("empty flush", wq.size(), 0);

        // Flush coinciding with the word-completing symbol
        for (int i = 0; i < 16; i++)
            step(-100, 100, 1, 1, i == 15);
        step(100, -100, 1, 1, 1);
        idle(3);
        expect_word("coinc full", 64'h55555555, 32, -1);
        expect_word("coinc next", 64'h2, 2, -1);
        chk("coinc words", wq.size(), 0);

        // Reset mid-word discards the partial word
        for (int i = 0; i < 7; i++)
            step(100, 100, 1, 1, 0);
        #2 RST = 0;
        #1;
        chk("mid rst valid_raw", valid_raw, 0);
        chk("mid rst raw", raw, 0);
        chk("mid rst raw_k", raw_k, 2);
        chk("mid rst valid_o", valid_o, 0);
        chk("mid rst data_o", data_o, 0);
        chk("mid rst nbits_o", nbits_o, 0);
        @(posedge CLK); #1 RST = 1;
        // Restart in reserved mode (QPSK)
        for (int i = 0; i < 16; i++)
            step(100, -100, 3, 1, 0);
        idle(3);
        expect_word("restart", 64'hAAAAAAAA, 32, -1);
        chk("restart words", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
